sfp_acc_ctrl: RTL and testbench

Sequencer that drives the SFP accumulate/ReLU stage over a full convolution layer.
- For each output row, it reads that row's partial sums for every kernel position (pass) from psum memory.
- It streams each read word into the SFP with the correct acc_en/relu_en.
- It writes the final activated row to output memory.
- Sits between psum SRAM, the SFP, and output SRAM; the data buses connect directly, and this block owns only control and addresses.

---
 rtl/sfp_acc_ctrl_pkg.sv | 23 ++
 rtl/sfp_acc_ctrl_if.sv | 24 ++
 rtl/sfp_acc_ctrl_pipe.sv | 44 ++++
 rtl/sfp_acc_ctrl.sv | 131 +++++++++++++
 tb/tb_sfp_acc_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sfp_acc_ctrl_pkg.sv
// Shared types and default widths for the SFP accumulate/ReLU sequencer.
package sfp_acc_ctrl_pkg;

  localparam int DEF_PASS_BW  = 4;
  localparam int DEF_ROW_BW   = 5;
  localparam int DEF_ADDR_BW  = 11;
  // Row field of a pipeline stage; widen it if the top is built with a larger ROW_BW.
  localparam int STAGE_ROW_BW = DEF_ROW_BW;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic                    valid;
    logic                    first;
    logic                    last;
    logic [STAGE_ROW_BW-1:0] row;
  } stage_t;

endpackage

// File: rtl/sfp_acc_ctrl_if.sv
// Psum-read, SFP-control and output-write strobes between the sequencer and the datapath.
interface sfp_acc_ctrl_if import sfp_acc_ctrl_pkg::*; #(
  parameter int ADDR_BW = DEF_ADDR_BW,
  parameter int ROW_BW  = DEF_ROW_BW
) ();
  logic               pmem_rd;
  logic [ADDR_BW-1:0] pmem_addr;
  logic               sfp_valid_in;
  logic               sfp_acc_en;
  logic               sfp_relu_en;
  logic               sfp_valid_out;
  logic               omem_wr;
  logic [ROW_BW-1:0]  omem_addr;

  modport master (
    output pmem_rd, pmem_addr, sfp_valid_in, sfp_acc_en, sfp_relu_en, omem_wr, omem_addr,
    input  sfp_valid_out
  );

  modport slave (
    input  pmem_rd, pmem_addr, sfp_valid_in, sfp_acc_en, sfp_relu_en, omem_wr, omem_addr,
    output sfp_valid_out
  );
endinterface

// File: rtl/sfp_acc_ctrl_pipe.sv
// Two-stage control delay line: stage 1 aligns with SRAM read data, stage 2 with SFP output.
module sfp_ctrl_pipe import sfp_acc_ctrl_pkg::*; (
  input  logic                    clk,
  input  logic                    reset,
  input  stage_t                  issue_i,
  input  logic                    relu_cfg_i,
  input  logic                    valid_out_i,
  output logic                    valid_in_o,
  output logic                    acc_en_o,
  output logic                    relu_en_o,
  output logic                    wr_o,
  output logic [STAGE_ROW_BW-1:0] wr_row_o,
  output logic                    mismatch_o
);

  stage_t                  s1_q;
  logic                    s2_valid_q;
  logic                    s2_last_q;
  logic [STAGE_ROW_BW-1:0] s2_row_q;

  // NOTE: non-blocking assignments so both stages shift on the same edge without ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_row_q   <= '0;
    end else begin
      s1_q       <= issue_i;
      s2_valid_q <= s1_q.valid;
      s2_last_q  <= s1_q.last;
      s2_row_q   <= s1_q.row;
    end
  end

  assign valid_in_o = s1_q.valid;
  assign acc_en_o   = s1_q.valid & ~s1_q.first;
  assign relu_en_o  = s1_q.valid & s1_q.last & relu_cfg_i;
  assign wr_o       = s2_valid_q & s2_last_q;
  assign wr_row_o   = wr_o ? s2_row_q : '0;
  // The SFP must present a result exactly when our stage-2 token says one is due.
  assign mismatch_o = s2_valid_q ^ valid_out_i;

endmodule

// File: rtl/sfp_acc_ctrl.sv
// Layer sequencer: walks rows (outer) and passes (inner) through psum memory into the SFP.
module sfp_acc_ctrl import sfp_acc_ctrl_pkg::*; #(
  parameter int PASS_BW = DEF_PASS_BW,
  parameter int ROW_BW  = DEF_ROW_BW,
  parameter int ADDR_BW = DEF_ADDR_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PASS_BW-1:0] n_pass,
  input  logic [ROW_BW-1:0]  n_row,
  input  logic               relu_cfg,
  input  logic               hold,
  sfp_acc_ctrl_if.master     bus,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state_q, state_d;
  logic [PASS_BW-1:0] n_pass_q, n_pass_d, pass_q, pass_d;
  logic [ROW_BW-1:0]  n_row_q, n_row_d, row_q, row_d;
  logic [ADDR_BW-1:0] base_q, base_d;
  logic               relu_q, relu_d, err_q, err_d;

  logic               rd, last_pass, last_row, accept, mismatch;
  logic               s1_valid;
  logic [STAGE_ROW_BW-1:0] wr_row;
  stage_t             issue;

  assign accept    = (state_q == ST_IDLE) && start;
  assign rd        = (state_q == ST_RUN) && !hold;
  assign last_pass = (pass_q == n_pass_q - PASS_BW'(1));
  assign last_row  = (row_q == n_row_q - ROW_BW'(1));

  // NOTE: every next-state variable gets its default first, so no branch can infer a latch.
  always_comb begin
    state_d  = state_q;
    n_pass_d = n_pass_q;
    n_row_d  = n_row_q;
    relu_d   = relu_q;
    pass_d   = pass_q;
    row_d    = row_q;
    base_d   = base_q;
    case (state_q)
      ST_IDLE: if (start) begin
        n_pass_d = n_pass;
        n_row_d  = n_row;
        relu_d   = relu_cfg;
        pass_d   = '0;
        row_d    = '0;
        base_d   = '0;
        state_d  = (n_pass == '0 || n_row == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: if (rd) begin
        // base tracks pass*n_row by repeated addition, so no multiplier is needed.
        if (last_pass) begin
          pass_d = '0;
          base_d = '0;
          row_d  = row_q + ROW_BW'(1);
          if (last_row) state_d = ST_DRAIN;
        end else begin
          pass_d = pass_q + PASS_BW'(1);
          base_d = base_q + ADDR_BW'(n_row_q);
        end
      end
      // Stage 2 is refilled only from stage 1, so an empty stage 1 means both drain this edge.
      ST_DRAIN: if (!s1_valid) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign err_d = accept ? 1'b0 : (err_q | mismatch);

  always_comb begin
    issue = '0;
    if (rd) begin
      issue.valid = 1'b1;
      issue.first = (pass_q == '0);
      issue.last  = last_pass;
      issue.row   = STAGE_ROW_BW'(row_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      n_pass_q <= '0;
      n_row_q  <= '0;
      relu_q   <= 1'b0;
      pass_q   <= '0;
      row_q    <= '0;
      base_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_pass_q <= n_pass_d;
      n_row_q  <= n_row_d;
      relu_q   <= relu_d;
      pass_q   <= pass_d;
      row_q    <= row_d;
      base_q   <= base_d;
      err_q    <= err_d;
    end
  end

  sfp_ctrl_pipe u_pipe (
    .clk         (clk),
    .reset       (reset),
    .issue_i     (issue),
    .relu_cfg_i  (relu_q),
    .valid_out_i (bus.sfp_valid_out),
    .valid_in_o  (s1_valid),
    .acc_en_o    (bus.sfp_acc_en),
    .relu_en_o   (bus.sfp_relu_en),
    .wr_o        (bus.omem_wr),
    .wr_row_o    (wr_row),
    .mismatch_o  (mismatch)
  );

  assign bus.pmem_rd      = rd;
  assign bus.pmem_addr    = rd ? (base_q + ADDR_BW'(row_q)) : '0;
  assign bus.sfp_valid_in = s1_valid;
  assign bus.omem_addr    = ROW_BW'(wr_row);

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_sfp_acc_ctrl.sv
// Randomized bench for sfp_acc_ctrl against a transaction-level model of the read/SFP/write schedule.
module tb_sfp_acc_ctrl;
  import sfp_acc_ctrl_pkg::*;

  localparam int PASS_BW = DEF_PASS_BW;
  localparam int ROW_BW  = DEF_ROW_BW;
  localparam int ADDR_BW = DEF_ADDR_BW;

  logic               clk = 1'b0;
  logic               reset, start, relu_cfg, hold;
  logic [PASS_BW-1:0] n_pass;
  logic [ROW_BW-1:0]  n_row;
  logic               busy, done, err;

  sfp_acc_ctrl_if #(.ADDR_BW(ADDR_BW), .ROW_BW(ROW_BW)) bus ();

  sfp_acc_ctrl #(.PASS_BW(PASS_BW), .ROW_BW(ROW_BW), .ADDR_BW(ADDR_BW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .n_pass   (n_pass),
    .n_row    (n_row),
    .relu_cfg (relu_cfg),
    .hold     (hold),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One scheduled psum read and everything the spec says follows from it.
  typedef struct {
    bit v;
    int addr;
    bit acc;
    bit relu;
    bit last;
    int row;
  } beat_t;

  bit err_model = 1'b0;
  bit vin_prev  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pmem_rd"}, bus.pmem_rd, 0);
    check({tag, "_valid_in"}, bus.sfp_valid_in, 0);
    check({tag, "_omem_wr"}, bus.omem_wr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Runs one layer. Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input int np, input int nr, input bit relu, input int hold_pct,
                        input logic [31:0] hold_mask, input int fault_beat, input int ign_start_at,
                        input int abort_at, input bit start_in_done,
                        output int done_cyc, output int n_reads);
    beat_t q[$];
    beat_t p1, p2, cur, none;
    int    wr_beats;
    bit    fault, busy_exp, finished;
    none     = '{default: 0};
    p1       = none;
    p2       = none;
    wr_beats = 0;
    finished = 1'b0;
    done_cyc = -1;
    n_reads  = 0;
    for (int r = 0; r < nr; r++)
      for (int p = 0; p < np; p++)
        q.push_back('{v: 1'b1, addr: p * nr + r, acc: (p != 0), relu: (relu && p == np - 1),
                      last: (p == np - 1), row: r});

    // Cycle 0: the start pulse, sampled in IDLE.
    start    = 1'b1;
    n_pass   = PASS_BW'(np);
    n_row    = ROW_BW'(nr);
    relu_cfg = relu;
    hold     = 1'($urandom_range(1, 0));
    bus.sfp_valid_out = vin_prev;
    #2;
    check_quiet("idle");
    check("idle_err", err, err_model);
    vin_prev  = bus.sfp_valid_in;
    err_model = 1'b0;
    tick();

    for (int t = 1; t <= 4000 && !finished; t++) begin
      start    = (t == ign_start_at);
      n_pass   = PASS_BW'($urandom);
      n_row    = ROW_BW'($urandom);
      relu_cfg = 1'($urandom);
      hold     = (t < 32 && hold_mask[t]) || ($urandom_range(99, 0) < hold_pct);
      busy_exp = (q.size() > 0) || p1.v || p2.v;
      cur = none;
      if (q.size() > 0 && !hold) cur = q.pop_front();
      fault = 1'b0;
      if (p2.v && p2.last) begin
        fault = (wr_beats == fault_beat);
        wr_beats++;
      end
      bus.sfp_valid_out = vin_prev & ~fault;
      #2;
      if (bus.pmem_rd === 1'b1) n_reads++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = t;
      check("pmem_rd", bus.pmem_rd, cur.v);
      if (cur.v) check("pmem_addr", bus.pmem_addr, cur.addr);
      check("sfp_valid_in", bus.sfp_valid_in, p1.v);
      if (p1.v) begin
        check("sfp_acc_en", bus.sfp_acc_en, p1.acc);
        check("sfp_relu_en", bus.sfp_relu_en, p1.relu);
      end
      check("omem_wr", bus.omem_wr, p2.v && p2.last);
      if (p2.v && p2.last) check("omem_addr", bus.omem_addr, p2.row);
      check("busy", busy, busy_exp);
      check("done", done, !busy_exp);
      check("err", err, err_model);
      if (bus.sfp_valid_out != p2.v) err_model = 1'b1;
      vin_prev = bus.sfp_valid_in;
      if (!busy_exp) begin
        finished = 1'b1;
        if (start_in_done) start = 1'b1;
      end
      if (t == abort_at) begin
        reset = 1'b1;
        tick();
        reset             = 1'b0;
        start             = 1'b0;
        vin_prev          = 1'b0;
        bus.sfp_valid_out = 1'b0;
        #2;
        check_quiet("abort");
        check("abort_err", err, 0);
        check("abort_omem_addr", bus.omem_addr, 0);
        check("abort_pmem_addr", bus.pmem_addr, 0);
        err_model = 1'b0;
        tick();
        return;
      end
      p2 = p1;
      p1 = cur;
      tick();
    end
    if (!finished) check("op_timeout", 0, 1);

    // One cycle after DONE: back in IDLE, any start pulsed during DONE ignored.
    start = 1'b0;
    bus.sfp_valid_out = vin_prev;
    #2;
    check_quiet("post");
    check("post_err", err, err_model);
    vin_prev = bus.sfp_valid_in;
    tick();
  endtask

  initial begin
    int dc, nrd;
    reset = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    relu_cfg = 1'b0;
    n_pass = '0;
    n_row = '0;
    bus.sfp_valid_out = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #2;
    check_quiet("reset");
    check("reset_err", err, 0);
    tick();

    // Full 3x3 layer, 16 rows, no stalls.
    run_op(9, 16, 1'b1, 0, 32'h0, -1, -1, -1, 1'b0, dc, nrd);
    check("t1_done_cycle", dc, 147);
    check("t1_reads", nrd, 144);

    // Single pass: plain load, no accumulate, no ReLU.
    run_op(1, 4, 1'b0, 0, 32'h0, -1, -1, -1, 1'b0, dc, nrd);
    check("t2_done_cycle", dc, 7);
    check("t2_reads", nrd, 4);

    // Stalls in cycles 2,3,4,6 push done from 9 to 13.
    run_op(3, 2, 1'b1, 0, 32'h0000_005C, -1, -1, -1, 1'b0, dc, nrd);
    check("t3_done_cycle", dc, 13);
    check("t3_reads", nrd, 6);

    // Empty layers finish immediately.
    run_op(3, 0, 1'b1, 0, 32'h0, -1, -1, -1, 1'b0, dc, nrd);
    check("t4_done_cycle", dc, 1);
    check("t4_reads", nrd, 0);
    run_op(0, 5, 1'b0, 0, 32'h0, -1, -1, -1, 1'b0, dc, nrd);
    check("t4b_done_cycle", dc, 1);

    // Abort mid-layer, then a clean follow-up run.
    run_op(9, 16, 1'b1, 0, 32'h0, -1, -1, 20, 1'b0, dc, nrd);
    run_op(1, 4, 1'b0, 0, 32'h0, -1, -1, -1, 1'b0, dc, nrd);
    check("t5_done_cycle", dc, 7);

    // Dropped SFP beat sets err; starts during RUN and DONE are ignored; next start clears err.
    run_op(3, 4, 1'b1, 20, 32'h0, 2, 5, -1, 1'b1, dc, nrd);
    check("t6_err_held", err, 1);
    run_op(2, 3, 1'b0, 0, 32'h0, -1, -1, -1, 1'b0, dc, nrd);

    for (int i = 0; i < 12; i++) begin
      run_op($urandom_range(15, 1), $urandom_range(31, 1), 1'($urandom),
             $urandom_range(50, 0), 32'h0, -1, $urandom_range(40, 2), -1, 1'($urandom), dc, nrd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
